pc_unit: RTL and testbench

- Program-counter / fetch-control stage that sits directly downstream of the branch decision logic.
- Consumes the resolved `jump` bit, plus call/return qualifiers, and produces the fetch address and fetch-valid for the instruction memory.
- Redirects squash younger in-flight instructions via a timed flush.
- Holds a small return-address stack (RAS) for call/return.

---
 rtl/pc_unit.sv | 125 ++++++++++++
 tb/tb_pc_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter / fetch control with timed redirect flush
// and a small circular return-address stack.
module pc_unit #(
  parameter int                 ADDR_W       = 16,
  parameter logic [ADDR_W-1:0]  RESET_VEC    = '0,
  parameter int                 FLUSH_CYCLES = 2,
  parameter int                 RAS_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              jump,
  input  logic [ADDR_W-1:0] target,
  input  logic              call,
  input  logic [ADDR_W-1:0] link_addr,
  input  logic              ret,
  output logic [ADDR_W-1:0] pc,
  output logic              if_valid,
  output logic              flush,
  output logic              ras_empty,
  output logic              ras_err
);

  localparam int CW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int PW  = $clog2(RAS_DEPTH);
  localparam int NW  = PW + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES - 1);
  localparam logic [NW-1:0] FULL     = NW'(RAS_DEPTH);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     top_q, top_d;
  logic [NW-1:0]     count_q, count_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [ADDR_W-1:0] ras_d [RAS_DEPTH];

  logic              redir;
  logic [ADDR_W-1:0] new_pc;
  logic [PW-1:0]     top_inc;

  assign top_inc = top_q + 1'b1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    top_d   = top_q;
    count_d = count_q;
    err_d   = err_q;
    ras_d   = ras_q;
    redir   = 1'b0;
    new_pc  = target;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN, FLUSH: begin
        // ret outranks jump, so at most one RAS op per edge
        if (ret) begin
          redir = 1'b1;
          if (count_q != '0) begin
            new_pc  = ras_q[top_q];
            top_d   = top_q - 1'b1;
            count_d = count_q - 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (jump) begin
          redir = 1'b1;
          if (call) begin
            ras_d[top_inc] = link_addr;
            top_d          = top_inc;
            if (count_q == FULL) err_d   = 1'b1;
            else                 count_d = count_q + 1'b1;
          end
        end
        if (redir) begin
          pc_d    = new_pc;
          state_d = FLUSH;
          cnt_d   = CNT_INIT;
        end else if (state_q == RUN) begin
          if (!stall) pc_d = pc_q + 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      cnt_q   <= '0;
      top_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      top_q   <= top_d;
      count_q <= count_d;
      err_q   <= err_d;
      ras_q   <= ras_d;
    end
  end

  assign pc        = pc_q;
  assign if_valid  = (state_q == RUN);
  assign flush     = (state_q == FLUSH);
  assign ras_empty = (count_q == '0);
  assign ras_err   = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: boot, wrap, stall,
// redirect flush timing and return-address stack.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, jump, call, ret;
  logic [15:0] target, link_addr;
  logic [15:0] pc;
  logic        if_valid, flush, ras_empty, ras_err;

  int n_cmp = 0;
  int n_bad = 0;

  pc_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .jump(jump),
    .target(target), .call(call), .link_addr(link_addr),
    .ret(ret), .pc(pc), .if_valid(if_valid), .flush(flush),
    .ras_empty(ras_empty), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; jump = 0; call = 0; ret = 0;
    target = '0; link_addr = '0;
  endtask

  task automatic goto(input logic [15:0] a);
    jump = 1; target = a;
    step();
    idle();
    step();
    step();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({pc, if_valid, flush, ras_empty, ras_err} !== {16'h0, 4'b0010}) begin
      n_bad++;
      $display("FAIL reset: got pc=%h v=%b f=%b e=%b err=%b want 0000 0 0 1 0",
               pc, if_valid, flush, ras_empty, ras_err);
    end
    rst_n = 1;
    step();
    n_cmp++;
    if (pc !== 16'h0 || if_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL boot: got pc=%h v=%b want 0000 1", pc, if_valid);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      n_cmp++;
      if (pc !== 16'(i) || if_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL count%0d: got pc=%h v=%b want %h 1", i, pc, if_valid, 16'(i));
      end
    end
  endtask

  task automatic test_wrap_stall();
    goto(16'hFFFE);
    n_cmp++;
    if (pc !== 16'hFFFE || if_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL goto: got pc=%h v=%b want fffe 1", pc, if_valid);
    end
    stall = 1;
    step();
    step();
    n_cmp++;
    if (pc !== 16'hFFFE) begin
      n_bad++;
      $display("FAIL stall: got %h want fffe", pc);
    end
    stall = 0;
    step();
    n_cmp++;
    if (pc !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL inc: got %h want ffff", pc);
    end
    step();
    n_cmp++;
    if (pc !== 16'h0000) begin
      n_bad++;
      $display("FAIL wrap: got %h want 0000", pc);
    end
  endtask

  task automatic test_jump_flush();
    goto(16'h0010);
    jump = 1; target = 16'h0100;
    step();
    idle();
    n_cmp++;
    if (pc !== 16'h0100 || flush !== 1'b1 || if_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL jmp0: got pc=%h f=%b v=%b want 0100 1 0", pc, flush, if_valid);
    end
    step();
    n_cmp++;
    if (pc !== 16'h0100 || flush !== 1'b1 || if_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL jmp1: got pc=%h f=%b v=%b want 0100 1 0", pc, flush, if_valid);
    end
    step();
    n_cmp++;
    if (pc !== 16'h0100 || flush !== 1'b0 || if_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL jmp2: got pc=%h f=%b v=%b want 0100 0 1", pc, flush, if_valid);
    end
    step();
    n_cmp++;
    if (pc !== 16'h0101) begin
      n_bad++;
      $display("FAIL jmp3: got %h want 0101", pc);
    end
  endtask

  task automatic test_back_to_back();
    stall = 1; jump = 1; target = 16'h0200;
    step();
    idle();
    n_cmp++;
    if (pc !== 16'h0200 || flush !== 1'b1) begin
      n_bad++;
      $display("FAIL stalljmp: got pc=%h f=%b want 0200 1", pc, flush);
    end
    jump = 1; target = 16'h0300;
    step();
    idle();
    n_cmp++;
    if (pc !== 16'h0300 || flush !== 1'b1) begin
      n_bad++;
      $display("FAIL rejmp: got pc=%h f=%b want 0300 1", pc, flush);
    end
    step();
    n_cmp++;
    if (flush !== 1'b1 || if_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rejmp1: got f=%b v=%b want 1 0", flush, if_valid);
    end
    step();
    n_cmp++;
    if (pc !== 16'h0300 || flush !== 1'b0 || if_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rejmp2: got pc=%h f=%b v=%b want 0300 0 1", pc, flush, if_valid);
    end
  endtask

  task automatic test_ras_nest();
    logic [15:0] exp [3];
    exp = '{16'h0033, 16'h0022, 16'h0011};
    for (int i = 0; i < 3; i++) begin
      jump = 1; call = 1; target = 16'h0400;
      link_addr = 16'(8'h11 * (i + 1));
      step();
    end
    idle();
    step();
    n_cmp++;
    if (ras_empty !== 1'b0) begin
      n_bad++;
      $display("FAIL ras_fill: got empty=%b want 0", ras_empty);
    end
    for (int i = 0; i < 3; i++) begin
      ret = 1; target = 16'h0999;
      step();
      n_cmp++;
      if (pc !== exp[i] || flush !== 1'b1) begin
        n_bad++;
        $display("FAIL ret%0d: got pc=%h f=%b want %h 1", i, pc, flush, exp[i]);
      end
    end
    idle();
    n_cmp++;
    if (ras_empty !== 1'b1 || ras_err !== 1'b0) begin
      n_bad++;
      $display("FAIL ras_drain: got e=%b err=%b want 1 0", ras_empty, ras_err);
    end
    step();
    step();
  endtask

  task automatic test_ras_overflow();
    for (int i = 1; i <= 5; i++) begin
      jump = 1; call = 1; target = 16'h0500;
      link_addr = 16'h00A0 + 16'(i);
      step();
    end
    idle();
    n_cmp++;
    if (ras_err !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf: got err=%b want 1", ras_err);
    end
    for (int i = 5; i >= 2; i--) begin
      ret = 1; target = 16'h0999;
      step();
      n_cmp++;
      if (pc !== 16'h00A0 + 16'(i)) begin
        n_bad++;
        $display("FAIL oret%0d: got %h want %h", i, pc, 16'h00A0 + 16'(i));
      end
    end
    n_cmp++;
    if (ras_empty !== 1'b1) begin
      n_bad++;
      $display("FAIL oempty: got %b want 1", ras_empty);
    end
    ret = 1; target = 16'h0777;
    step();
    idle();
    n_cmp++;
    if (pc !== 16'h0777 || ras_err !== 1'b1 || ras_empty !== 1'b1) begin
      n_bad++;
      $display("FAIL unf: got pc=%h err=%b e=%b want 0777 1 1", pc, ras_err, ras_empty);
    end
  endtask

  task automatic test_reset_mid_flush();
    jump = 1; call = 1; target = 16'h0600; link_addr = 16'h0055;
    step();
    idle();
    n_cmp++;
    if (flush !== 1'b1 || ras_empty !== 1'b0 || ras_err !== 1'b1) begin
      n_bad++;
      $display("FAIL preRst: got f=%b e=%b err=%b want 1 0 1", flush, ras_empty, ras_err);
    end
    #2;
    rst_n = 0;
    #1;
    n_cmp++;
    if ({pc, if_valid, flush, ras_empty, ras_err} !== {16'h0, 4'b0010}) begin
      n_bad++;
      $display("FAIL asyncRst: got pc=%h v=%b f=%b e=%b err=%b want 0000 0 0 1 0",
               pc, if_valid, flush, ras_empty, ras_err);
    end
    step();
    rst_n = 1;
    step();
    step();
    n_cmp++;
    if (pc !== 16'h0001 || if_valid !== 1'b1 || flush !== 1'b0) begin
      n_bad++;
      $display("FAIL postRst: got pc=%h v=%b f=%b want 0001 1 0", pc, if_valid, flush);
    end
  endtask

  initial begin
    test_reset();
    test_wrap_stall();
    test_jump_flush();
    test_back_to_back();
    test_ras_nest();
    test_ras_overflow();
    test_reset_mid_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
